// File: rtl/trigger_arm_sequencer_pkg.sv
// Shared types and defaults for the trigger arm sequencer: FSM state encoding,
// default counter widths and small state-classification helpers.
package trigger_arm_sequencer_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned TMO_W_DEF       = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_FIRE    = 3'd3,
    ST_DONE    = 3'd4,
    ST_TMO     = 3'd5
  } state_e;

  // States from which a host arm request starts a new sequence.
  function automatic logic accepts_arm(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TMO);
  endfunction

  function automatic logic is_armed(input state_e s);
    return (s == ST_ARMED) || (s == ST_HOLDOFF);
  endfunction

endpackage

// File: rtl/trigger_arm_sequencer_sync_edge_detect.sv
// Synchronises the asynchronous trigger, keeps one history flop and emits a
// registered one-cycle pulse on the selected edge polarity.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trig_i,
  input  logic pol_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_i};
      hist_q <= sync_last;
      edge_q <= pol_i ? (hist_q & ~sync_last) : (~hist_q & sync_last);
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/trigger_arm_sequencer.sv
// Arms on a host command, qualifies synchronised trigger edges by count, applies
// a holdoff and emits a one-cycle capture_go; supports timeout and auto-rearm.
module trigger_arm_sequencer
  import trigger_arm_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TMO_W       = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trig_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             edge_pol_i,
  input  logic             autorearm_i,
  input  logic [CNT_W-1:0] events_cfg_i,
  input  logic [CNT_W-1:0] holdoff_cfg_i,
  input  logic [TMO_W-1:0] timeout_cfg_i,
  output logic             capture_go_o,
  output logic             armed_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cfg_events_q, cfg_events_d;
  logic [CNT_W-1:0] cfg_hold_q, cfg_hold_d;
  logic [TMO_W-1:0] cfg_tmo_q, cfg_tmo_d;
  logic             cfg_pol_q, cfg_pol_d;
  logic             cfg_autorearm_q, cfg_autorearm_d;
  logic             timeout_q, timeout_d;
  logic             capture_go_q, armed_q, done_q;
  logic             edge_pulse;
  logic             target_hit;
  logic [CNT_W-1:0] evt_sat_inc;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk    (clk),
    .reset_n(reset_n),
    .trig_i (trig_i),
    .pol_i  (cfg_pol_q),
    .edge_o (edge_pulse)
  );

  // Compared one bit wider so an all-ones count cannot wrap past the target.
  assign target_hit  = ({1'b0, evt_q} + (CNT_W+1)'(1)) >= {1'b0, cfg_events_q};
  assign evt_sat_inc = (evt_q == '1) ? evt_q : evt_q + CNT_W'(1);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    evt_d           = evt_q;
    hcnt_d          = hcnt_q;
    tmo_d           = tmo_q;
    timeout_d       = timeout_q;
    cfg_events_d    = cfg_events_q;
    cfg_hold_d      = cfg_hold_q;
    cfg_tmo_d       = cfg_tmo_q;
    cfg_pol_d       = cfg_pol_q;
    cfg_autorearm_d = cfg_autorearm_q;

    if (abort_i) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_TMO: begin
          if (arm_i && accepts_arm(state_q)) begin
            state_d         = ST_ARMED;
            evt_d           = '0;
            timeout_d       = 1'b0;
            tmo_d           = timeout_cfg_i;
            cfg_events_d    = (events_cfg_i == '0) ? CNT_W'(1) : events_cfg_i;
            cfg_hold_d      = holdoff_cfg_i;
            cfg_tmo_d       = timeout_cfg_i;
            cfg_pol_d       = edge_pol_i;
            cfg_autorearm_d = autorearm_i;
          end
        end
        ST_ARMED: begin
          if (edge_pulse) begin
            evt_d = evt_sat_inc;
            if (target_hit) begin
              if (cfg_hold_q != '0) begin
                state_d = ST_HOLDOFF;
                hcnt_d  = cfg_hold_q - CNT_W'(1);
              end else begin
                state_d = ST_FIRE;
              end
            end
          end
          // A completing edge in the expiry cycle wins over the timeout.
          if (cfg_tmo_q != '0) begin
            tmo_d = tmo_q - TMO_W'(1);
            if ((tmo_q == TMO_W'(1)) && (state_d == ST_ARMED)) begin
              state_d   = ST_TMO;
              timeout_d = 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hcnt_q == '0) state_d = ST_FIRE;
          else              hcnt_d  = hcnt_q - CNT_W'(1);
        end
        ST_FIRE: begin
          if (cfg_autorearm_q) begin
            state_d = ST_ARMED;
            evt_d   = '0;
            tmo_d   = cfg_tmo_q;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      evt_q           <= '0;
      hcnt_q          <= '0;
      tmo_q           <= '0;
      timeout_q       <= 1'b0;
      cfg_events_q    <= '0;
      cfg_hold_q      <= '0;
      cfg_tmo_q       <= '0;
      cfg_pol_q       <= 1'b0;
      cfg_autorearm_q <= 1'b0;
      capture_go_q    <= 1'b0;
      armed_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      evt_q           <= evt_d;
      hcnt_q          <= hcnt_d;
      tmo_q           <= tmo_d;
      timeout_q       <= timeout_d;
      cfg_events_q    <= cfg_events_d;
      cfg_hold_q      <= cfg_hold_d;
      cfg_tmo_q       <= cfg_tmo_d;
      cfg_pol_q       <= cfg_pol_d;
      cfg_autorearm_q <= cfg_autorearm_d;
      capture_go_q    <= (state_d == ST_FIRE);
      armed_q         <= is_armed(state_d);
      done_q          <= (state_d == ST_DONE);
    end
  end

  assign capture_go_o = capture_go_q;
  assign armed_o      = armed_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign evt_cnt_o    = evt_q;

endmodule

// File: tb/tb_trigger_arm_sequencer.sv
// Directed bench for trigger_arm_sequencer: inputs change and outputs are
// sampled on the falling clock edge, expected values are hand-derived.
module tb_trigger_arm_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trig_i, arm_i, abort_i, edge_pol_i, autorearm_i;
  logic [15:0] events_cfg_i, holdoff_cfg_i;
  logic [31:0] timeout_cfg_i;
  logic        capture_go_o, armed_o, done_o, timeout_o;
  logic [15:0] evt_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trigger_arm_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trig_i       (trig_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .edge_pol_i   (edge_pol_i),
    .autorearm_i  (autorearm_i),
    .events_cfg_i (events_cfg_i),
    .holdoff_cfg_i(holdoff_cfg_i),
    .timeout_cfg_i(timeout_cfg_i),
    .capture_go_o (capture_go_o),
    .armed_o      (armed_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .evt_cnt_o    (evt_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ticks until capture_go is seen; n = -1 if the budget runs out.
  task automatic wait_go(input int max_cycles, output int n);
    n = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      tick();
      if (capture_go_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_evt(input logic [15:0] target, input int max_cycles, output int n);
    n = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      tick();
      if (evt_cnt_o == target) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic arm_with(input logic pol, input logic ar, input logic [15:0] ev,
                          input logic [15:0] ho, input logic [31:0] tmo);
    edge_pol_i    = pol;
    autorearm_i   = ar;
    events_cfg_i  = ev;
    holdoff_cfg_i = ho;
    timeout_cfg_i = tmo;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int gap_bad;

    reset_n = 1'b0;
    trig_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0;
    edge_pol_i = 1'b0; autorearm_i = 1'b0;
    events_cfg_i = '0; holdoff_cfg_i = '0; timeout_cfg_i = '0;
    ticks(2);
    check("rst_capture_go", capture_go_o, 0);
    check("rst_armed",      armed_o,      0);
    check("rst_done",       done_o,       0);
    check("rst_timeout",    timeout_o,    0);
    check("rst_evt_cnt",    evt_cnt_o,    0);
    reset_n = 1'b1;
    ticks(2);

    // T1: single rising edge, no holdoff.
    arm_with(1'b0, 1'b0, 16'd1, 16'd0, 32'd0);
    check("t1_armed", armed_o, 1);
    trig_i = 1'b1;
    wait_go(20, n);
    check("t1_go_latency", n, 4);
    tick();
    check("t1_go_one_cycle", capture_go_o, 0);
    check("t1_done",    done_o,    1);
    check("t1_evt_cnt", evt_cnt_o, 1);
    check("t1_armed_after", armed_o, 0);
    trig_i = 1'b0;
    ticks(6);

    // T2: three edges then 10-cycle holdoff; edges in holdoff ignored.
    arm_with(1'b0, 1'b0, 16'd3, 16'd10, 32'd0);
    for (int e = 0; e < 2; e++) begin
      trig_i = 1'b1; ticks(4);
      trig_i = 1'b0; ticks(4);
    end
    check("t2_evt_after_two", evt_cnt_o, 2);
    trig_i = 1'b1;
    wait_evt(16'd3, 20, n);
    check("t2_third_edge_latency", n, 4);
    check("t2_armed_holdoff", armed_o, 1);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if ((i % 2) == 0) trig_i = ~trig_i;
      tick();
      if (capture_go_o) begin
        n = i;
        break;
      end
    end
    check("t2_holdoff_cycles", n, 10);
    check("t2_evt_holds_3", evt_cnt_o, 3);
    tick();
    check("t2_done", done_o, 1);
    trig_i = 1'b0;
    ticks(6);

    // T3: timeout with no edges, then re-arm clears the sticky flag.
    arm_with(1'b0, 1'b0, 16'd1, 16'd0, 32'd100);
    pulses = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (capture_go_o) pulses++;
    end
    check("t3_no_timeout_at_99", timeout_o, 0);
    check("t3_armed_at_99",      armed_o,   1);
    tick();
    if (capture_go_o) pulses++;
    check("t3_timeout_at_100", timeout_o, 1);
    check("t3_left_armed",     armed_o,   0);
    check("t3_not_done",       done_o,    0);
    check("t3_no_capture",     pulses,    0);
    arm_with(1'b0, 1'b0, 16'd1, 16'd0, 32'd100);
    check("t3_rearm_clears_timeout", timeout_o, 0);
    check("t3_rearm_armed",          armed_o,   1);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("t3_abort_disarms", armed_o, 0);

    // T4: auto-rearm, two edges per capture, six edges.
    arm_with(1'b0, 1'b1, 16'd2, 16'd0, 32'd0);
    pulses = 0;
    gap_bad = 0;
    for (int i = 0; i < 56; i++) begin
      trig_i = (i < 48) && ((i % 8) < 4);
      tick();
      if (capture_go_o) pulses++;
      else if ((pulses >= 1) && (pulses < 3) && !armed_o) gap_bad++;
    end
    check("t4_pulses",       pulses,    3);
    check("t4_armed_gaps",   gap_bad,   0);
    check("t4_evt_cleared",  evt_cnt_o, 0);
    check("t4_still_armed",  armed_o,   1);
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    ticks(4);

    // T5: abort (with a simultaneous arm) on the cycle FIRE would be decided.
    arm_with(1'b0, 1'b0, 16'd1, 16'd0, 32'd0);
    trig_i = 1'b1;
    ticks(3);
    abort_i = 1'b1;
    arm_i   = 1'b1;
    tick();
    abort_i = 1'b0;
    arm_i   = 1'b0;
    check("t5_go_suppressed", capture_go_o, 0);
    check("t5_idle_armed",    armed_o,      0);
    check("t5_idle_done",     done_o,       0);
    check("t5_evt_held",      evt_cnt_o,    0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (capture_go_o) pulses++;
    end
    check("t5_no_late_go",    pulses,  0);
    check("t5_arm_ignored",   armed_o, 0);

    // T6: falling-edge polarity, reset during holdoff.
    arm_with(1'b1, 1'b0, 16'd1, 16'd20, 32'd0);
    trig_i = 1'b0;
    wait_evt(16'd1, 10, n);
    check("t6_fall_latency", n, 4);
    check("t6_in_holdoff",   armed_o, 1);
    ticks(3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_armed",   armed_o,      0);
    check("t6_rst_evt",     evt_cnt_o,    0);
    check("t6_rst_go",      capture_go_o, 0);
    check("t6_rst_done",    done_o,       0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (capture_go_o) pulses++;
    end
    check("t6_no_go_after_reset", pulses, 0);
    arm_with(1'b1, 1'b0, 16'd1, 16'd0, 32'd0);
    trig_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (capture_go_o) pulses++;
    end
    check("t6_rise_ignored_go",  pulses,    0);
    check("t6_rise_ignored_evt", evt_cnt_o, 0);
    trig_i = 1'b0;
    wait_go(20, n);
    check("t6_fall_go_latency", n, 4);
    check("t6_fall_evt", evt_cnt_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
